// File: rtl/mmio_bridge.sv
// Memory-mapped bridge between the CPU bus, the synchronous RAM, an LED register and a
// debounced switch port. Every read returns data exactly one cycle after the request.
module mmio_bridge #(
   parameter int                DATA_W     = 16,
   parameter int                ADDR_W     = 9,
   parameter logic [ADDR_W-1:0] LED_ADDR   = 9'h100,
   parameter logic [ADDR_W-1:0] SW_ADDR    = 9'h140,
   parameter int                DEB_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        mem_cmd,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic [7:0]        ram_addr,
   output logic              ram_write,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout,
   input  logic [7:0]        sw_in,
   output logic [7:0]        ledr,
   output logic              access_err
);

   localparam logic [1:0] CMD_READ  = 2'b01;
   localparam logic [1:0] CMD_WRITE = 2'b10;
   localparam logic [1:0] CMD_RSVD  = 2'b11;

   localparam int                CNT_W   = $clog2(DEB_CYCLES) + 1;
   localparam logic [CNT_W-1:0] DEB_MAX = CNT_W'(DEB_CYCLES - 1);

   typedef enum logic [1:0] {
      SEL_NONE,
      SEL_RAM,
      SEL_LED,
      SEL_SW
   } sel_e;

   sel_e             sel_q, sel_d;
   logic [7:0]       led_q, led_d;
   logic [7:0]       ledRd_q, ledRd_d;
   logic [7:0]       swRd_q, swRd_d;
   logic             err_q, err_d;
   logic [7:0]       sync1_q, sync2_q;
   logic [7:0]       cand_q, cand_d;
   logic [7:0]       swStable_q, swStable_d;
   logic [CNT_W-1:0] debCnt_q, debCnt_d;

   logic isRam;
   logic isLed;
   logic isSw;
   logic isIllegal;

   assign isRam     = ~mem_addr[ADDR_W-1];
   assign isLed     = (mem_addr == LED_ADDR);
   assign isSw      = (mem_addr == SW_ADDR);
   assign isIllegal = mem_addr[ADDR_W-1] & ~isLed & ~isSw;

   assign ram_addr   = mem_addr[7:0];
   assign ram_din    = write_data;
   assign ram_write  = (mem_cmd == CMD_WRITE) & isRam;
   assign ledr       = led_q;
   assign access_err = err_q;

   // Bus decode: a read latches the source (and a snapshot of LED/switch state) so
   // peripheral data lines up with the RAM's one-cycle read latency.
   always_comb begin
      sel_d   = SEL_NONE;
      led_d   = led_q;
      ledRd_d = ledRd_q;
      swRd_d  = swRd_q;
      err_d   = err_q;
      case (mem_cmd)
         CMD_READ: begin
            if (isRam) begin
               sel_d = SEL_RAM;
            end else if (isLed) begin
               sel_d   = SEL_LED;
               ledRd_d = led_q;
            end else if (isSw) begin
               sel_d  = SEL_SW;
               swRd_d = swStable_q;
            end else begin
               err_d = 1'b1;
            end
         end
         CMD_WRITE: begin
            if (isLed) begin
               led_d = write_data[7:0];
            end else if (isSw || isIllegal) begin
               err_d = 1'b1;
            end
         end
         CMD_RSVD: err_d = 1'b1;
         default: ;
      endcase
   end

   // Debouncer: a synchronized value must hold for DEB_CYCLES edges as a candidate
   // before it is accepted; any change of the candidate restarts the count.
   always_comb begin
      cand_d     = cand_q;
      swStable_d = swStable_q;
      debCnt_d   = debCnt_q;
      if (sync2_q != cand_q) begin
         cand_d   = sync2_q;
         debCnt_d = '0;
      end else if (cand_q != swStable_q) begin
         if (debCnt_q == DEB_MAX) begin
            swStable_d = cand_q;
            debCnt_d   = '0;
         end else begin
            debCnt_d = debCnt_q + CNT_W'(1);
         end
      end else begin
         debCnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q      <= SEL_NONE;
         led_q      <= '0;
         ledRd_q    <= '0;
         swRd_q     <= '0;
         err_q      <= 1'b0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         cand_q     <= '0;
         swStable_q <= '0;
         debCnt_q   <= '0;
      end else begin
         sel_q      <= sel_d;
         led_q      <= led_d;
         ledRd_q    <= ledRd_d;
         swRd_q     <= swRd_d;
         err_q      <= err_d;
         sync1_q    <= sw_in;
         sync2_q    <= sync1_q;
         cand_q     <= cand_d;
         swStable_q <= swStable_d;
         debCnt_q   <= debCnt_d;
      end
   end

   always_comb begin
      case (sel_q)
         SEL_RAM: read_data = ram_dout;
         SEL_LED: read_data = {{(DATA_W-8){1'b0}}, ledRd_q};
         SEL_SW:  read_data = {{(DATA_W-8){1'b0}}, swRd_q};
         default: read_data = '0;
      endcase
   end

endmodule
